// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: sizes, the Rcon seed and polynomial, xtime, and FSM states.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;
  localparam logic [7:0]  RCON_INIT = 8'h01;
  localparam logic [7:0]  RCON_POLY = 8'h1b;

  typedef enum logic [0:0] {IDLE, EXPAND} state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion round: RotWord, SubWord on the last word, Rcon, then the XOR chain.
module aes_key_round
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] w_i,
  input  logic [7:0]           rcon_i,
  output logic [AES_KEY_W-1:0] w_next_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0  = w_i[127:96];
  assign w1  = w_i[95:64];
  assign w2  = w_i[63:32];
  assign w3  = w_i[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot[8*b +: 8]),
      .out_o (sub[8*b +: 8])
    );
  end

  assign t  = sub ^ {rcon_i, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign w_next_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box cell: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] InvExp = 8'hfe;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] sq;

  always_comb begin
    // a^254 is the inverse for a != 0 and yields 0 for a == 0, as the S-box requires.
    inv = 8'h01;
    sq  = in_i;
    for (int i = 0; i < 8; i++) begin
      if (InvExp[i]) inv = gf_mul(inv, sq);
      sq = gf_mul(sq, sq);
    end
    out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: one expansion round per cycle into an 11-slot key
// store, with a registered read port indexed by round.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic                 busy,
  output logic                 keys_ok,
  output logic                 done,
  input  logic [3:0]           rd_idx,
  output logic [AES_KEY_W-1:0] rd_key
);

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [7:0]           rcon_q;
  logic [AES_KEY_W-1:0] work_q;
  logic [AES_KEY_W-1:0] slot_q [AES_NR+1];
  logic [AES_KEY_W-1:0] rd_key_q;
  logic                 keys_ok_q;
  logic                 done_q;
  logic [AES_KEY_W-1:0] w_next;
  logic [AES_KEY_W-1:0] rd_mux;

  aes_key_round u_round (
    .w_i      (work_q),
    .rcon_i   (rcon_q),
    .w_next_o (w_next)
  );

  // Out-of-range indices fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= AES_NR; i++) begin
      if (rd_idx == 4'(i)) rd_mux = slot_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rcon_q    <= RCON_INIT;
      work_q    <= '0;
      rd_key_q  <= '0;
      keys_ok_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i <= AES_NR; i++) slot_q[i] <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_key_q <= rd_mux;
      unique case (state_q)
        IDLE: begin
          if (key_valid) begin
            slot_q[0] <= key_in;
            work_q    <= key_in;
            cnt_q     <= 4'd1;
            rcon_q    <= RCON_INIT;
            keys_ok_q <= 1'b0;
            state_q   <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= AES_NR; i++) begin
            if (cnt_q == 4'(i)) slot_q[i] <= w_next;
          end
          work_q <= w_next;
          rcon_q <= xtime(rcon_q);
          if (cnt_q == 4'(AES_NR)) begin
            state_q   <= IDLE;
            keys_ok_q <= 1'b1;
            done_q    <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q == EXPAND);
  assign keys_ok   = keys_ok_q;
  assign done      = done_q;
  assign rd_key    = rd_key_q;

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative AES-128 key-schedule controller. It accepts a 128-bit cipher key over a valid/ready handshake and sequences a single-round expansion datapath (one SubWord of 4 S-boxes plus a generated Rcon) over 10 cycles. The 11 round keys go into an internal key store, which the round-sequencing cipher core reads by round index. It replaces the fully unrolled 40-S-box expansion in area-constrained builds.

## Interface
- NR, 10, number of expansion rounds. Only 10 (AES-128) is supported.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_in  in  128  cipher key; word w0 = key_in[127:96].
- key_valid  in  1  key_in is valid this cycle.
- key_ready  out  1  block accepts a key; high exactly when the FSM is in IDLE.
- busy  out  1  expansion in progress; high exactly in EXPAND.
- keys_ok  out  1  all 11 slots hold the schedule of the last accepted key.
- done  out  1  one-cycle pulse when expansion completes.
- rd_idx  in  4  round-key index, 0..10.
- rd_key  out  128  registered round key for rd_idx.

## Operation
- FSM has two states: IDLE and EXPAND.
- Reset values:
  - state=IDLE, so key_ready=1 and busy=0.
  - keys_ok=0, done=0, rd_key=0.
  - All 11 key-store slots=0, round counter cnt=0, rcon=8'h01.
- IDLE → EXPAND on key_valid & key_ready at that edge:
  - slot[0] ← key_in, work register ← key_in.
  - cnt ← 1, rcon ← 8'h01, keys_ok ← 0.
- EXPAND, each cycle:
  - next = key_round(work, rcon).
  - slot[cnt] ← next, work ← next.
  - rcon ← xtime(rcon), where xtime(r) = {r[6:0],0} ^ (r[7] ? 8'h1b : 0). The sequence is 01,02,04,08,10,20,40,80,1b,36.
  - cnt ← cnt+1.
- EXPAND → IDLE on the edge that writes slot[10]; the same edge sets keys_ok ← 1 and done ← 1 (done for one cycle only).
- key_round(w, rc):
  - t = SubWord(RotWord(w3)) ^ {rc,24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- key_valid while key_ready=0 is ignored; the key is not queued. The source must hold key_valid until it is accepted.
- A new key accepted while keys_ok=1 clears keys_ok at the accept edge. Slots 1..10 keep stale contents until they are rewritten.
- Read port:
  - Every cycle, rd_key ← (rd_idx ≤ 10) ? slot[rd_idx] : 128'h0.
  - There is no read/write bypass. A read of a slot written on the same edge returns the old value.
  - Reads are allowed in any state. Data is guaranteed only while keys_ok=1.
- Reset asserted mid-expansion aborts immediately and applies all reset values. A new key is required afterwards.
- cnt is 4 bits and never exceeds 10.

## Timing
- Key accepted at edge E0.
- slot[k] is written at edge Ek, for k = 1..10.
- busy is high in the cycles after E0 through E10.
- keys_ok and done rise after E10.
- key_ready returns high after E10.
- Key-to-keys_ok latency is 10 cycles. Back-to-back throughput is one key per 11 cycles (one IDLE cycle between jobs).
- rd_key latency is 1 cycle from rd_idx.
- The critical path is one RotWord → 4 S-boxes → XOR chain of 4 words. No multi-cycle paths.

## Structure
- Shared package aes_pkg holds:
  - constants AES_NR=10, AES_KEY_W=128, RCON_INIT=8'h01, RCON_POLY=8'h1b;
  - the xtime function;
  - the state enum {IDLE, EXPAND}.
- Sub-module aes_key_round: purely combinational (w[127:0], rcon[7:0]) → w_next[127:0]. It instantiates 4 existing sbox cells.
- The controller holds the FSM, cnt, rcon register, work register, 11×128 key store, and read register.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - slot1 = a0fafe1788542cb123a339392a6c7605;
  - slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - done exactly 10 cycles after accept.
- All-zero key:
  - slot1 = 62636363626363636263636362636363;
  - slot10 = b4ef5bcb3e92e21123e951cf6f8f188e;
  - slot0 reads 0.
- key_valid held through EXPAND with a different key_in: that key is ignored. It is accepted on the first IDLE cycle, after which keys_ok drops and then re-rises after 10 cycles.
- rst pulsed at cycle 5 of EXPAND:
  - all outputs return to reset values asynchronously;
  - rd_idx=3 then reads 0;
  - the next key expands correctly.
- Read sweep rd_idx 0..15 after keys_ok: slots 0..10 return the correct keys with 1-cycle latency; indices 11..15 return 0.
- Rcon check: probe the rcon register across EXPAND and confirm the sequence 01,02,04,08,10,20,40,80,1b,36.
